// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg
// Shared definitions for the CPU memory/IO bridge:
//   - bus widths (byte, CPU address)
//   - I/O window base (address bits 17:16) and register offsets (address bits 2:0)
//   - region type and the address decode helper
// Ports: none (package).
package mem_io_bridge_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 32;

  localparam logic [1:0] IO_BASE  = 2'b11;
  localparam logic [2:0] IO_UART  = 3'd0;
  localparam logic [2:0] IO_CNT   = 3'd4;
  localparam logic [2:0] IO_CNT_1 = 3'd5;
  localparam logic [2:0] IO_CNT_2 = 3'd6;
  localparam logic [2:0] IO_CNT_3 = 3'd7;

  typedef enum logic {
    REG_RAM = 1'b0,
    REG_IO  = 1'b1
  } region_e;

  // Address bits 17:16 pick the region; everything outside the I/O window is RAM.
  function automatic region_e decode_region(input logic [1:0] hi_bits);
    return (hi_bits == IO_BASE) ? REG_IO : REG_RAM;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if
// Bundles every bus the bridge touches: CPU byte bus, RAM port, UART TX/RX
// and the program-stop flag.
//   slave  modport: the bridge side (mem_io_bridge)
//   master modport: the environment side (CPU, RAM, UART)
// Parameter RAM_AW sets the width of ram_a.
interface mem_io_bridge_if
  import mem_io_bridge_pkg::*;
#(
  parameter int RAM_AW = 17
);
  // CPU byte bus
  logic              rdy_in;
  logic [ADDR_W-1:0] cpu_a;
  logic [BYTE_W-1:0] cpu_dout;
  logic              cpu_wr;
  logic [BYTE_W-1:0] cpu_din;
  logic              io_buffer_full;
  // RAM port (1-cycle synchronous RAM)
  logic [RAM_AW-1:0] ram_a;
  logic              ram_wr;
  logic [BYTE_W-1:0] ram_wdata;
  logic [BYTE_W-1:0] ram_rdata;
  // UART
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  // status
  logic              prog_done;

  modport slave (
    input  rdy_in, cpu_a, cpu_dout, cpu_wr, ram_rdata, tx_ready, rx_data, rx_valid,
    output cpu_din, io_buffer_full, ram_a, ram_wr, ram_wdata, tx_data, tx_valid,
           rx_ack, prog_done
  );

  modport master (
    output rdy_in, cpu_a, cpu_dout, cpu_wr, ram_rdata, tx_ready, rx_data, rx_valid,
    input  cpu_din, io_buffer_full, ram_a, ram_wr, ram_wdata, tx_data, tx_valid,
           rx_ack, prog_done
  );

endinterface

// File: rtl/mem_io_bridge_io_tx_fifo.sv
// mem_io_bridge_io_tx_fifo
// UART TX byte FIFO: circular buffer with naturally wrapping pointers and an
// occupancy count. near_full is registered and warns the CPU early enough to
// cover writes already in flight.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_data         enqueue request and byte (dropped when full,
//                           unless a pop happens in the same cycle)
//   pop_ready, pop_data     consumer ready; head byte (valid when !empty)
//   full, empty, near_full  status; near_full = free entries <= FULL_MARGIN
// TX_DEPTH must be a power of two and at least 4.
module mem_io_bridge_io_tx_fifo #(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_ready,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic       near_full
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

  logic [7:0]    mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          near_full_reg;
  logic          pop, push_ok;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign pop     = ~empty & pop_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = push & (~full | pop);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      near_full_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg     <= count_next;
      near_full_reg <= ((DEPTH_C - count_next) <= MARGIN_C);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data  = mem[rd_ptr_reg];
  assign near_full = near_full_reg;

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge
// Decodes CPU byte-bus accesses to the RAM or the memory-mapped I/O window
// (address bits 17:16 == 2'b11), keeps a free-running 32-bit cycle counter,
// buffers UART TX bytes and returns read data one cycle after the address.
// I/O map (offset = address bits 2:0):
//   0 W: push byte to TX FIFO (0x00 dropped)   R: RX byte or 0, pops RX
//   4 W: set sticky prog_done                  R: counter byte 0, snapshots counter
//   5..7 R: snapshot bytes 1..3                others: read 0, writes ignored
// Ports:
//   clk_in, rst_in  clock, asynchronous active-low reset
//   bus             mem_io_bridge_if.slave (CPU bus, RAM, UART, prog_done)
// Build option: define IO_RX_EN to enable the UART RX read path; without it
// offset 0 reads return 0 and rx_ack stays low.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2,
  parameter int RAM_AW      = 17
) (
  input  logic            clk_in,
  input  logic            rst_in,
  mem_io_bridge_if.slave  bus
);

  region_e           region, region_reg;
  logic [2:0]        offset;
  logic              bus_rd, io_rd, io_wr, tx_push;
  logic [BYTE_W-1:0] io_rdata, io_data_reg, din_hold_reg, cpu_din;
  logic              rd_live_reg;
  logic [31:0]       cycle_cnt_reg, cnt_latch_reg;
  logic              prog_done_reg;
  logic              fifo_full, fifo_empty;
  logic              unused_bits;

  // ---------------- decode ----------------
  assign region  = decode_region(bus.cpu_a[17:16]);
  assign offset  = bus.cpu_a[2:0];
  assign bus_rd  = bus.rdy_in & ~bus.cpu_wr;
  assign io_rd   = bus_rd & (region == REG_IO);
  assign io_wr   = bus.rdy_in & bus.cpu_wr & (region == REG_IO);
  assign tx_push = io_wr & (offset == IO_UART) & (bus.cpu_dout != '0);

  assign bus.ram_a     = bus.cpu_a[RAM_AW-1:0];
  assign bus.ram_wdata = bus.cpu_dout;
  assign bus.ram_wr    = bus.rdy_in & bus.cpu_wr & (region == REG_RAM);

  // ---------------- I/O read data (address cycle) ----------------
  always_comb begin
    io_rdata = '0;
    case (offset)
      IO_UART: begin
`ifdef IO_RX_EN
        if (bus.rx_valid) io_rdata = bus.rx_data;
`endif
      end
      IO_CNT:   io_rdata = cycle_cnt_reg[7:0];
      IO_CNT_1: io_rdata = cnt_latch_reg[15:8];
      IO_CNT_2: io_rdata = cnt_latch_reg[23:16];
      IO_CNT_3: io_rdata = cnt_latch_reg[31:24];
      default:  io_rdata = '0;
    endcase
  end

  // ---------------- read pipeline, counter, status ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      region_reg    <= REG_RAM;
      io_data_reg   <= '0;
      rd_live_reg   <= 1'b0;
      din_hold_reg  <= '0;
      cycle_cnt_reg <= '0;
      cnt_latch_reg <= '0;
      prog_done_reg <= 1'b0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      rd_live_reg   <= bus_rd;
      if (bus_rd) begin
        region_reg  <= region;
        io_data_reg <= io_rdata;
      end
      // Remember the last returned byte so cpu_din holds across idle/write cycles.
      if (rd_live_reg) din_hold_reg <= cpu_din;
      if (io_rd && offset == IO_CNT) cnt_latch_reg <= cycle_cnt_reg;
      if (io_wr && offset == IO_CNT) prog_done_reg <= 1'b1;
    end
  end

  // ram_rdata is only meaningful in the cycle right after a read address.
  assign cpu_din = rd_live_reg ? ((region_reg == REG_IO) ? io_data_reg : bus.ram_rdata)
                               : din_hold_reg;
  assign bus.cpu_din   = cpu_din;
  assign bus.prog_done = prog_done_reg;

  // ---------------- UART RX ----------------
`ifdef IO_RX_EN
  logic rx_ack_reg;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_ack_reg <= 1'b0;
    end else begin
      rx_ack_reg <= io_rd & (offset == IO_UART) & bus.rx_valid;
    end
  end
  // Gate with rx_valid so an acknowledge never reaches an empty RX.
  assign bus.rx_ack = rx_ack_reg & bus.rx_valid;
  assign unused_bits = ^{bus.cpu_a[ADDR_W-1:18], fifo_full};
`else
  assign bus.rx_ack  = 1'b0;
  assign unused_bits = ^{bus.cpu_a[ADDR_W-1:18], fifo_full, bus.rx_data, bus.rx_valid};
`endif

  // ---------------- UART TX ----------------
  mem_io_bridge_io_tx_fifo #(
    .TX_DEPTH   (TX_DEPTH),
    .FULL_MARGIN(FULL_MARGIN)
  ) u_io_tx_fifo (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .push     (tx_push),
    .push_data(bus.cpu_dout),
    .pop_ready(bus.tx_ready),
    .pop_data (bus.tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .near_full(bus.io_buffer_full)
  );

  assign bus.tx_valid = ~fifo_empty;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge
// Directed bench for mem_io_bridge with a 1-cycle synchronous RAM model,
// a TX scoreboard (bytes queued on write, checked on each tx handshake) and a
// read scoreboard (expected byte queued on address, checked a cycle later).
// RX expectations follow the IO_RX_EN build option.
module tb_mem_io_bridge;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mem_io_bridge_if #(.RAM_AW(17)) bus ();

  mem_io_bridge #(
    .TX_DEPTH   (16),
    .FULL_MARGIN(2),
    .RAM_AW     (17)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

`ifdef IO_RX_EN
  localparam logic [7:0] RX_EXP     = 8'h37;
  localparam logic       RX_ACK_EXP = 1'b1;
`else
  localparam logic [7:0] RX_EXP     = 8'h00;
  localparam logic       RX_ACK_EXP = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] tb_cnt;

  // 1-cycle synchronous RAM
  logic [7:0] ram [0:131071];
  always @(posedge clk_in) begin
    if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_a];
  end

  // Reference clock count since reset release
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) tb_cnt <= '0;
    else         tb_cnt <= tb_cnt + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // TX monitor: every handshake must match the oldest queued byte
  always @(negedge clk_in) begin
    if (rst_in && bus.tx_valid && bus.tx_ready) begin
      logic [8:0] e;
      e = (tx_q.size() != 0) ? {1'b0, tx_q.pop_front()} : 9'h100;
      check("tx_data", {23'd0, 1'b0, bus.tx_data}, {23'd0, e});
      $display("tx byte 0x%02h", bus.tx_data);
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [7:0] d);
    bus.rdy_in   = 1'b1;
    bus.cpu_wr   = w;
    bus.cpu_a    = a;
    bus.cpu_dout = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    bus.rdy_in = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    drive(1'b1, a, d);
    step();
    $display("write 0x%05h <= 0x%02h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    drive(1'b0, a, 8'h00);
    step();
    check(tag, {24'd0, bus.cpu_din}, {24'd0, rd_q.pop_front()});
    $display("read  0x%05h -> 0x%02h", a, bus.cpu_din);
  endtask

  logic [31:0] snap;
  logic [31:0] dw;

  initial begin
    bus.rdy_in   = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_a    = '0;
    bus.cpu_dout = '0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    // Reset state
    #2;
    check("rst_cpu_din",   {24'd0, bus.cpu_din}, 32'd0);
    check("rst_full",      {31'd0, bus.io_buffer_full}, 32'd0);
    check("rst_tx_valid",  {31'd0, bus.tx_valid}, 32'd0);
    check("rst_prog_done", {31'd0, bus.prog_done}, 32'd0);
    check("rst_rx_ack",    {31'd0, bus.rx_ack}, 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;

    // RAM write then read back
    drive(1'b1, 32'h0000_0123, 8'hA5);
    check("ram_wr_wcyc", {31'd0, bus.ram_wr}, 32'd1);
    check("ram_a",       {15'd0, bus.ram_a}, 32'h123);
    check("ram_wdata",   {24'd0, bus.ram_wdata}, 32'hA5);
    step();
    drive(1'b0, 32'h0000_0123, 8'h00);
    check("ram_wr_rcyc", {31'd0, bus.ram_wr}, 32'd0);
    rd_q.push_back(8'hA5);
    step();
    check("ram_rd", {24'd0, bus.cpu_din}, {24'd0, rd_q.pop_front()});
    step();
    check("din_hold", {24'd0, bus.cpu_din}, 32'hA5);

    // Upper RAM region (bits 17:16 = 10)
    wr(32'h0002_0055, 8'h3C);
    rd_chk("ram_hi", 32'h0002_0055, 8'h3C);

    // Zero byte to TX is dropped; unmapped I/O write/read
    wr(32'h0003_0000, 8'h00);
    check("tx_zero_drop", {31'd0, bus.tx_valid}, 32'd0);
    wr(32'h0003_0001, 8'h55);
    check("io_unmapped_wr", {31'd0, bus.tx_valid}, 32'd0);
    rd_chk("io_unmapped_rd", 32'h0003_0002, 8'h00);

    // prog_done is sticky
    drive(1'b1, 32'h0003_0004, 8'h01);
    check("io_no_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    step();
    check("prog_done_set", {31'd0, bus.prog_done}, 32'd1);
    repeat (3) step();
    check("prog_done_hold", {31'd0, bus.prog_done}, 32'd1);

    // Fill 14 with tx_ready low: near-full rises after the 14th push
    for (int i = 1; i <= 14; i++) begin
      tx_q.push_back(8'h48);
      wr(32'h0003_0000, 8'h48);
      if (i == 13) check("full_after13", {31'd0, bus.io_buffer_full}, 32'd0);
      if (i == 14) check("full_after14", {31'd0, bus.io_buffer_full}, 32'd1);
    end
    check("tx_valid_filled", {31'd0, bus.tx_valid}, 32'd1);

    // Drain: tx_valid contiguous for 14 cycles
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      check("tx_contig", {31'd0, bus.tx_valid}, 32'd1);
      step();
    end
    check("drain_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("drain_full",     {31'd0, bus.io_buffer_full}, 32'd0);
    check("drain_q_empty",  32'(tx_q.size()), 32'd0);
    bus.tx_ready = 1'b0;

    // Five distinct bytes, one simultaneous push/pop, then asynchronous reset
    rd_chk("ram_rd_again", 32'h0000_0123, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      tx_q.push_back(8'h11 + 8'(i));
      wr(32'h0003_0000, 8'h11 + 8'(i));
    end
    check("din_hold_wr", {24'd0, bus.cpu_din}, 32'hA5);
    bus.tx_ready = 1'b1;
    tx_q.push_back(8'h16);
    wr(32'h0003_0000, 8'h16);
    check("pre_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    tx_q.delete();
    check("arst_tx_valid",  {31'd0, bus.tx_valid}, 32'd0);
    check("arst_full",      {31'd0, bus.io_buffer_full}, 32'd0);
    check("arst_cpu_din",   {24'd0, bus.cpu_din}, 32'd0);
    check("arst_prog_done", {31'd0, bus.prog_done}, 32'd0);
    bus.tx_ready = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b1;

    // Cycle counter snapshot after 1000 clocks
    repeat (1000) @(posedge clk_in);
    #1;
    snap = tb_cnt;
    rd_chk("cnt_b0", 32'h0003_0004, snap[7:0]);
    dw[7:0] = bus.cpu_din;
    rd_chk("cnt_b1", 32'h0003_0005, snap[15:8]);
    dw[15:8] = bus.cpu_din;
    rd_chk("cnt_b2", 32'h0003_0006, snap[23:16]);
    dw[23:16] = bus.cpu_din;
    rd_chk("cnt_b3", 32'h0003_0007, snap[31:24]);
    dw[31:24] = bus.cpu_din;
    check("cnt_window", {31'd0, (dw >= 32'd1000 && dw <= 32'd1010)}, 32'd1);
    check("prog_done_after_rst", {31'd0, bus.prog_done}, 32'd0);

    // UART RX read
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h37;
    rd_chk("rx_data", 32'h0003_0000, RX_EXP);
    check("rx_ack_pulse", {31'd0, bus.rx_ack}, {31'd0, RX_ACK_EXP});
    step();
    check("rx_ack_once", {31'd0, bus.rx_ack}, 32'd0);
    bus.rx_valid = 1'b0;
    rd_chk("rx_none", 32'h0003_0000, 8'h00);
    check("rx_ack_idle", {31'd0, bus.rx_ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
